// File: rtl/frame_scan_ctrl_if.sv
// Coordinate stream from frame_scan_ctrl to the per-pixel datapath:
// one signed (x, y) beat per valid/ready transfer, with frame markers.
interface frame_scan_ctrl_if #(
  parameter int W = 16
);
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic                valid;
  logic                ready;
  logic                first;
  logic                lastx;
  logic                last;

  modport master (
    output x, y, valid, first, lastx, last,
    input  ready
  );

  modport slave (
    input  x, y, valid, first, lastx, last,
    output ready
  );
endinterface

// File: rtl/frame_scan_ctrl.sv
// Raster scan sequencer: walks an X_SIZE x Y_SIZE frame row-major and streams
// pan/zoom-adjusted signed world coordinates, with config shadowed per frame.
module frame_scan_ctrl #(
  parameter int X_SIZE = 1024,
  parameter int Y_SIZE = 1024,
  parameter int W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                cfg_continuous,
  input  logic signed [W-1:0] cfg_cx,
  input  logic signed [W-1:0] cfg_cy,
  input  logic [3:0]          cfg_zoom,
  frame_scan_ctrl_if.master   pix,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_count
);

  localparam int CW = $clog2(X_SIZE);
  localparam int RW = $clog2(Y_SIZE);
  localparam logic [CW-1:0] COL_LAST = CW'(X_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(Y_SIZE - 1);
  localparam logic [W-1:0]  HALF_X   = W'(X_SIZE / 2);
  localparam logic [W-1:0]  HALF_Y   = W'(Y_SIZE / 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [W-1:0]  sh_cx_q, sh_cx_d;
  logic [W-1:0]  sh_cy_q, sh_cy_d;
  logic [3:0]    sh_zoom_q, sh_zoom_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [15:0]   count_q, count_d;

  logic valid_s;
  logic lastx_s;
  logic last_s;

  // Two's-complement wrap is intended: the sum is simply truncated to W bits.
  function automatic logic [W-1:0] world(input logic [W-1:0] pan,
                                         input logic [W-1:0] offset,
                                         input logic [3:0]   zoom);
    return pan + (offset << zoom);
  endfunction

  assign valid_s = (state_q == S_SCAN);
  assign lastx_s = (col_q == COL_LAST);
  assign last_s  = lastx_s && (row_q == ROW_LAST);

  // Next-state, counter, shadow and coordinate computation.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    sh_cx_d   = sh_cx_q;
    sh_cy_d   = sh_cy_q;
    sh_zoom_d = sh_zoom_q;
    count_d   = count_q;
    x_d       = x_q;
    y_d       = y_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ARM;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ARM: begin
          sh_cx_d   = cfg_cx;
          sh_cy_d   = cfg_cy;
          sh_zoom_d = cfg_zoom;
          col_d     = {CW{1'b0}};
          row_d     = {RW{1'b0}};
          state_d   = S_SCAN;
        end
        S_SCAN: begin
          if (pix.ready) begin
            if (last_s) begin
              state_d = S_DONE;
            end else if (lastx_s) begin
              col_d = {CW{1'b0}};
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            state_d = S_SCAN;
          end
        end
        S_DONE: begin
          count_d = count_q + 16'd1;
          if (cfg_continuous) begin
            state_d = S_ARM;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Coordinates are precomputed for the beat that will be presented next,
    // so during a stall they are recomputed from unchanged inputs and hold.
    if (state_d == S_SCAN) begin
      x_d = world(sh_cx_d, W'(col_d) - HALF_X, sh_zoom_d);
      y_d = world(sh_cy_d, HALF_Y - W'(row_d), sh_zoom_d);
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // State, counters, shadow configuration and coordinate registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      col_q     <= {CW{1'b0}};
      row_q     <= {RW{1'b0}};
      sh_cx_q   <= {W{1'b0}};
      sh_cy_q   <= {W{1'b0}};
      sh_zoom_q <= 4'd0;
      x_q       <= {W{1'b0}};
      y_q       <= {W{1'b0}};
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      sh_cx_q   <= sh_cx_d;
      sh_cy_q   <= sh_cy_d;
      sh_zoom_q <= sh_zoom_d;
      x_q       <= x_d;
      y_q       <= y_d;
      count_q   <= count_d;
    end
  end

  assign pix.valid   = valid_s;
  assign pix.x       = x_q;
  assign pix.y       = y_q;
  assign pix.first   = valid_s && (col_q == {CW{1'b0}}) && (row_q == {RW{1'b0}});
  assign pix.lastx   = valid_s && lastx_s;
  assign pix.last    = valid_s && last_s;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
  assign frame_count = count_q;

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Randomized and directed bench for frame_scan_ctrl against a beat-index
// reference model, with literal expectations from the 4x4 worked examples.
module tb_frame_scan_ctrl;
  localparam int X = 4;
  localparam int Y = 4;
  localparam int W = 16;
  localparam int N = X * Y;

  typedef struct {
    int x;
    int y;
    int f;
    int lx;
    int l;
  } beat_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                abort;
  logic                cfg_continuous;
  logic signed [W-1:0] cfg_cx;
  logic signed [W-1:0] cfg_cy;
  logic [3:0]          cfg_zoom;
  logic                busy;
  logic                frame_done;
  logic [15:0]         frame_count;

  frame_scan_ctrl_if #(.W(W)) pix();

  frame_scan_ctrl #(.X_SIZE(X), .Y_SIZE(Y), .W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_continuous (cfg_continuous),
    .cfg_cx         (cfg_cx),
    .cfg_cy         (cfg_cy),
    .cfg_zoom       (cfg_zoom),
    .pix            (pix),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 arm, 2 scanning beat m_k, 3 done.
  int m_phase, m_k, m_count, m_cx, m_cy, m_zoom;

  beat_t q[$];
  beat_t ref_q[$];
  int    done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_k     = 0;
    m_count = 0;
    m_cx    = 0;
    m_cy    = 0;
    m_zoom  = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (abort) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start) m_phase = 1;
        1: begin
          m_cx    = cfg_cx;
          m_cy    = cfg_cy;
          m_zoom  = cfg_zoom;
          m_k     = 0;
          m_phase = 2;
        end
        2: if (pix.ready) begin
          if (m_k == N - 1) m_phase = 3;
          else m_k++;
        end
        3: begin
          m_count = (m_count + 1) % 65536;
          m_phase = cfg_continuous ? 1 : 0;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // Inputs change only at posedge+1, so they are stable at every sampling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    start          = 1'b0;
    abort          = 1'b0;
    cfg_continuous = 1'b0;
    pix.ready      = 1'b1;
    reset          = 1'b1;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready, output int edges);
    edges = 0;
    while (!frame_done && edges < budget) begin
      tick();
      edges++;
      if (rand_ready) pix.ready = 1'($urandom_range(0, 1));
    end
    pix.ready = 1'b1;
    chk("frame_done_within_budget", frame_done, 1);
  endtask

  // Per-cycle comparison against the model, hold check and beat capture.
  initial begin
    int               xo, yo, ev;
    logic signed [15:0] ex16, ey16;
    int               stall_prev, px, py, pf, plx, pl;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      ev   = (m_phase == 2);
      xo   = (m_k % X) - X / 2;
      yo   = Y / 2 - (m_k / X);
      ex16 = 16'(m_cx + (xo <<< m_zoom));
      ey16 = 16'(m_cy + (yo <<< m_zoom));
      chk("valid", pix.valid, ev);
      chk("busy", busy, int'(m_phase != 0));
      chk("frame_done", frame_done, int'(m_phase == 3));
      chk("frame_count", frame_count, m_count);
      chk("first", pix.first, int'(ev && m_k == 0));
      chk("lastx", pix.lastx, int'(ev && (m_k % X) == X - 1));
      chk("last", pix.last, int'(ev && m_k == N - 1));
      if (ev) begin
        chk("x", pix.x, ex16);
        chk("y", pix.y, ey16);
      end
      if (stall_prev != 0 && pix.valid) begin
        chk("hold_x", pix.x, px);
        chk("hold_y", pix.y, py);
        chk("hold_first", pix.first, pf);
        chk("hold_lastx", pix.lastx, plx);
        chk("hold_last", pix.last, pl);
      end
      stall_prev = pix.valid && !pix.ready;
      px = pix.x; py = pix.y; pf = pix.first; plx = pix.lastx; pl = pix.last;
      if (pix.valid && pix.ready) q.push_back('{pix.x, pix.y, pix.first, pix.lastx, pix.last});
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    int e, run, seen, fc0, done0;
    int gaps[$];
    cfg_cx   = '0;
    cfg_cy   = '0;
    cfg_zoom = 4'd0;
    do_reset();

    chk("rst_x", pix.x, 0);
    chk("rst_y", pix.y, 0);
    chk("rst_valid", pix.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);

    // Single unstalled frame, 4x4, no pan or zoom.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_valid", pix.valid, 0);
    tick();
    chk("first_valid", pix.valid, 1);
    chk("first_flag", pix.first, 1);
    chk("first_x", pix.x, -2);
    chk("first_y", pix.y, 2);
    wait_done(100, 1'b0, e);
    chk("start_to_done_edges", e + 2, N + 2);
    tick();
    chk("idle_after_frame", busy, 0);
    chk("single_frame_count", frame_count, 1);
    chk("single_done_pulses", done_cnt, 1);
    chk("single_beats", q.size(), N);
    if (q.size() == N) begin
      chk("row0_end_x", q[3].x, 1);
      chk("row0_end_y", q[3].y, 2);
      chk("row0_end_lastx", q[3].lx, 1);
      chk("final_x", q[N-1].x, 1);
      chk("final_y", q[N-1].y, -1);
      chk("final_last", q[N-1].l, 1);
    end
    ref_q = q;

    // Same frame under random backpressure must yield the same beats.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400, 1'b1, e);
    chk("bp_beats", q.size(), ref_q.size());
    for (int i = 0; i < q.size() && i < ref_q.size(); i++) begin
      chk("bp_x", q[i].x, ref_q[i].x);
      chk("bp_y", q[i].y, ref_q[i].y);
      chk("bp_markers", q[i].f * 4 + q[i].lx * 2 + q[i].l,
          ref_q[i].f * 4 + ref_q[i].lx * 2 + ref_q[i].l);
    end

    // Pan/zoom shadowing: cfg_cx changes mid-frame.
    do_reset();
    cfg_cx   = 16'sd100;
    cfg_cy   = -16'sd50;
    cfg_zoom = 4'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    cfg_cx = 16'sd0;
    wait_done(100, 1'b0, e);
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, 1'b0, e);
    chk("pan_beats", q.size(), 2 * N);
    if (q.size() == 2 * N) begin
      chk("pan_first_x", q[0].x, 92);
      chk("pan_first_y", q[0].y, -42);
      chk("pan_final_x", q[N-1].x, 104);
      chk("pan_final_y", q[N-1].y, -54);
      chk("pan_next_first_x", q[N].x, -8);
      chk("pan_next_first_y", q[N].y, -42);
    end
    cfg_cx   = '0;
    cfg_cy   = '0;
    cfg_zoom = 4'd0;

    // Continuous mode: three frames, cleared during the third.
    do_reset();
    run  = 0;
    seen = 0;
    cfg_continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    while (!(done_cnt >= 3 && !busy) && e < 300) begin
      tick();
      e++;
      if (pix.valid) begin
        if (seen != 0 && run > 0) gaps.push_back(run);
        seen = 1;
        run  = 0;
      end else if (seen != 0) begin
        run++;
      end
      if (done_cnt == 2 && pix.valid) cfg_continuous = 1'b0;
    end
    chk("cont_within_budget", int'(e < 300), 1);
    chk("cont_done_pulses", done_cnt, 3);
    chk("cont_frame_count", frame_count, 3);
    chk("cont_idle", busy, 0);
    chk("cont_gap_count", gaps.size(), 2);
    foreach (gaps[i]) chk("cont_gap_len", gaps[i], 2);

    // start while scanning is ignored; abort on beat 5; abort+start in idle.
    fc0   = frame_count;
    done0 = done_cnt;
    start = 1'b1;
    tick();
    e = 0;
    while (!(m_phase == 2 && m_k == 5) && e < 50) begin
      tick();
      e++;
    end
    chk("abort_reached_beat5", int'(m_phase == 2 && m_k == 5), 1);
    chk("beat5_x", pix.x, (5 % X) - X / 2);
    abort = 1'b1;
    tick();
    chk("abort_valid", pix.valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", frame_done, 0);
    tick();
    chk("abort_start_idle", busy, 0);
    abort = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    chk("abort_frame_count", frame_count, fc0);
    chk("abort_done_pulses", done_cnt, done0);

    // Asynchronous reset in the middle of a scan.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_reset_valid", pix.valid, 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_valid", pix.valid, 0);
    chk("async_busy", busy, 0);
    chk("async_x", pix.x, 0);
    chk("async_y", pix.y, 0);
    chk("async_frame_count", frame_count, 0);
    chk("async_first", pix.first, 0);
    tick();
    reset = 1'b0;

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      start          = ($urandom_range(0, 3) == 0);
      abort          = ($urandom_range(0, 60) == 0);
      pix.ready      = ($urandom_range(0, 3) != 0);
      cfg_continuous = ($urandom_range(0, 2) == 0);
      cfg_cx         = 16'($urandom);
      cfg_cy         = 16'($urandom);
      cfg_zoom       = 4'($urandom_range(0, 15));
      tick();
    end
    start     = 1'b0;
    abort     = 1'b0;
    pix.ready = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_scan_ctrl.md
# frame_scan_ctrl

Sequences raster coordinate generation for the rendering pipeline.
- On a start command (single-shot) or back-to-back (continuous mode), it scans one full frame of X_SIZE × Y_SIZE pixel positions.
- It maps each position to a signed, pan/zoom-adjusted world coordinate and streams it to the downstream per-pixel datapath over a valid/ready handshake.
- It brackets each frame with first/lastx/last markers and a frame_done pulse.
- Configuration is shadowed at frame start, so host writes never tear a frame.

## Interface
- X_SIZE, 1024: columns per frame; power of two, ≥ 2.
- Y_SIZE, 1024: rows per frame; power of two, ≥ 2.
- W, 16: coordinate width (signed).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled start request; honoured only in IDLE.
- abort  in  1  synchronous abort; highest priority after reset.
- cfg_continuous  in  1  start the next frame automatically after DONE.
- cfg_cx  in  W  signed pan offset added to x.
- cfg_cy  in  W  signed pan offset added to y.
- cfg_zoom  in  4  left-shift applied to raster offsets (0..15).
- ready  in  1  downstream accepts the current beat.
- x  out  W  signed world x of the current beat.
- y  out  W  signed world y of the current beat.
- valid  out  1  beat present.
- first  out  1  current beat is the frame's first pixel.
- lastx  out  1  current beat is the last column of its row.
- last  out  1  current beat is the final pixel of the frame.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse after the final beat is accepted.
- frame_count  out  16  completed frames; wraps at 65535→0.

## Operation
- Internal counters:
  - col runs 0..X_SIZE-1.
  - row runs 0..Y_SIZE-1.
- Raster offsets:
  - xo = col − X_SIZE/2.
  - yo = Y_SIZE/2 − row.
  - The top-left beat has the most-negative x and the most-positive y.
  - The scan is row-major: col increments fastest, and rows descend in y.
- Outputs: x = sh_cx + (xo <<< sh_zoom) and y = sh_cy + (yo <<< sh_zoom), each truncated to W bits in two's complement. Overflow wraps silently.
- Shadow registers sh_cx, sh_cy and sh_zoom load from cfg_* only on entry to SCAN. cfg changes mid-frame have no effect until the next frame.
- States:
  - IDLE:
    - valid=0.
    - If start=1, go to ARM.
  - ARM (1 cycle):
    - Load the shadow registers.
    - Set col=0, row=0.
    - Go to SCAN.
  - SCAN:
    - valid=1.
    - On ready: if last, go to DONE; else advance col, or wrap col to 0 and increment row.
  - DONE (1 cycle):
    - valid=0, frame_done=1, frame_count+1.
    - Go to ARM if cfg_continuous=1 (sampled in DONE); otherwise go to IDLE.
- Markers:
  - first = (col==0 && row==0).
  - lastx = (col==X_SIZE−1).
  - last = lastx && (row==Y_SIZE−1).
  - All markers are gated by valid.
- Stability: while valid=1 && ready=0, x, y, first, lastx and last hold exactly.
- start outside IDLE is ignored. It is not queued.
- abort:
  - Any state goes to IDLE at the next edge, and valid drops.
  - No frame_done pulse; frame_count is unchanged.
  - abort and start in the same cycle in IDLE: abort wins, and the block stays IDLE.
- Clearing cfg_continuous mid-frame lets the current frame complete; the block then goes to IDLE.

## Timing
- Reset values:
  - State IDLE; col=0, row=0.
  - x=0, y=0; all shadow registers 0.
  - valid, first, lastx, last, busy and frame_done all 0; frame_count=0.
- Outputs are registered or decoded from registered state only. There is no combinational path from ready, start or cfg_* to any output.
- start sampled at edge N:
  - ARM after edge N; busy=1.
  - SCAN after edge N+1, with valid=1 and the first beat presented.
  - Start-to-first-valid latency is 2 cycles.
- Throughput is one beat per cycle while ready=1. A frame with ready held high takes 2 + X_SIZE·Y_SIZE + 1 cycles from start to frame_done.
- Continuous mode gives a 2-cycle bubble between frames (DONE, ARM).

## Test plan
- Reset: assert reset mid-SCAN, asynchronously → all outputs return to their reset values immediately, with no clock edge needed.
- Single frame: X_SIZE=4, Y_SIZE=4, cx=cy=0, zoom=0, ready=1, one start pulse.
  - Expect 16 beats, first (−2,2) with first=1.
  - Row ends at (1,2) with lastx=1; last beat (1,−1) with last=1.
  - frame_done pulses exactly once, frame_count=1, then IDLE.
- Backpressure: same setup, ready toggles pseudo-randomly → x, y and the markers stay stable while ready=0, and the beat sequence is identical to the unstalled run.
- Pan/zoom shadowing: cx=100, cy=−50, zoom=2 at start, then cfg_cx changes to 0 mid-frame.
  - First beat is (92,−42).
  - All beats in the frame use cx=100; the next frame uses 0.
- Continuous mode: set cfg_continuous=1 and run 3 frames, then clear it during frame 3.
  - Exactly 3 frame_done pulses, each followed by a 2-cycle valid gap.
  - Then IDLE with frame_count=3.
- Abort and start-while-busy:
  - start during SCAN is ignored.
  - abort on beat 5 → next cycle IDLE, valid=0, no frame_done, frame_count unchanged.
  - abort together with start in IDLE keeps the block IDLE.
